// File: rtl/bcd_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// bcd_pkg : shared widths, scan state type and BCD code check
// Revision: 1.0
// ============================================================================
package bcd_pkg;

   localparam int BCD_W = 4;
   localparam int DEC_W = 10;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   function automatic logic bcd_is_valid(input logic [BCD_W-1:0] code);
      return (code <= 4'd9);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// bcd_digit_decoder : one BCD code to a one-hot decimal, zero for codes 10..15
// Revision: 1.0
// ============================================================================
module bcd_digit_decoder
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] bcd,
   output logic [DEC_W-1:0] dec,
   output logic             invalid
);

   always_comb begin
      invalid = !bcd_is_valid(bcd);
      dec     = '0;
      if (!invalid) begin
         dec = DEC_W'(1) << bcd;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bcd_scan_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// bcd_scan_decoder : latches a DIGITS-wide BCD word and scans it onto a
// one-hot decimal LED bus. Optional macro: LEADING_ZERO_BLANK_EN.
// Revision: 1.0
// ============================================================================
module bcd_scan_decoder
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BCD_W*DIGITS-1:0] in_bcd,
   output logic [DIGITS-1:0]       digit_sel,
   output logic [DEC_W-1:0]        out,
   output logic                    err
);

   localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

   state_t                    state_q, state_d;
   logic [BCD_W*DIGITS-1:0]   word_q,  word_d;
   logic [TICK_W-1:0]         tick_q,  tick_d;
   logic [IDX_W-1:0]          idx_q,   idx_d;
   logic [DIGITS-1:0]         blank_q, blank_d;
   logic                      err_q,   err_d;
   logic [DIGITS-1:0]         sel_q,   sel_d;
   logic [DEC_W-1:0]          out_q,   out_d;

   logic                      frame_end;
   logic                      xfer;
   logic                      word_has_bad;
   logic [DIGITS-1:0]         new_blank;
   logic [BCD_W-1:0]          cur_code;
   logic [DEC_W-1:0]          cur_dec;
   logic                      cur_invalid;

   assign frame_end = (state_q == SCAN) && (tick_q == TICK_LAST) && (idx_q == IDX_LAST);
   assign in_ready  = (state_q == IDLE) || frame_end;
   assign xfer      = in_valid && in_ready;

   always_comb begin
      word_has_bad = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         word_has_bad = word_has_bad | !bcd_is_valid(in_bcd[k*BCD_W +: BCD_W]);
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Walk down from the most significant digit; the first non-zero code
   // (valid or not) ends the blank run. Digit 0 is never blanked.
   logic lead_zero;
   always_comb begin
      lead_zero = 1'b1;
      new_blank = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         lead_zero    = lead_zero && (in_bcd[k*BCD_W +: BCD_W] == '0);
         new_blank[k] = lead_zero;
      end
   end
`else
   assign new_blank = '0;
`endif

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      tick_d  = tick_q;
      idx_d   = idx_q;
      blank_d = blank_q;
      err_d   = err_q;
      if (xfer) begin
         state_d = SCAN;
         word_d  = in_bcd;
         tick_d  = '0;
         idx_d   = '0;
         blank_d = new_blank;
         err_d   = err_q | word_has_bad;
      end else if (state_q == SCAN) begin
         if (tick_q == TICK_LAST) begin
            tick_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end else begin
            tick_d = tick_q + 1'b1;
         end
      end
   end

   // Select from the next-state word/index so the registered outputs line up
   // with the cycle the scan position takes effect.
   always_comb begin
      cur_code = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_d == IDX_W'(k)) begin
            cur_code = word_d[k*BCD_W +: BCD_W];
         end
      end
   end

   bcd_digit_decoder u_digit_decoder (
      .bcd     (cur_code),
      .dec     (cur_dec),
      .invalid (cur_invalid)
   );

   always_comb begin
      sel_d = '0;
      out_d = '0;
      if (state_d == SCAN) begin
         sel_d = DIGITS'(1) << idx_d;
         out_d = (blank_d[idx_d] || cur_invalid) ? '0 : cur_dec;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         tick_q  <= '0;
         idx_q   <= '0;
         blank_q <= '0;
         err_q   <= 1'b0;
         sel_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         tick_q  <= tick_d;
         idx_q   <= idx_d;
         blank_q <= blank_d;
         err_q   <= err_d;
         sel_q   <= sel_d;
         out_q   <= out_d;
      end
   end

   assign digit_sel = sel_q;
   assign out       = out_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_bcd_scan_decoder : randomized and directed bench with a frame-position model
// Revision: 1.0
// ============================================================================
module tb_bcd_scan_decoder;

   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;
   localparam int FRAME    = DIGITS * SCAN_DIV;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_bcd;
   logic [3:0]  digit_sel;
   logic [9:0]  out;
   logic        err;

   int checks = 0;
   int errors = 0;

   // Model: whether a word is being shown and the cycle position inside the frame.
   bit          m_active = 1'b0;
   int          m_pos    = 0;
   logic [15:0] m_word   = '0;
   bit          m_err    = 1'b0;
   bit          m_xfer   = 1'b0;

   bcd_scan_decoder #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bcd    (in_bcd),
      .digit_sel (digit_sel),
      .out       (out),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int nib(input logic [15:0] w, input int d);
      return int'(w[d*4 +: 4]);
   endfunction

   function automatic logic m_ready();
      return !m_active || (m_pos == FRAME - 1);
   endfunction

   function automatic logic [3:0] exp_sel();
      if (!m_active) return 4'b0000;
      return 4'(1 << (m_pos / SCAN_DIV));
   endfunction

   function automatic logic [9:0] exp_out();
      int d;
      int code;
      bit blanked;
      if (!m_active) return 10'b0;
      d    = m_pos / SCAN_DIV;
      code = nib(m_word, d);
      if (code > 9) return 10'b0;
      blanked = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blanked = (d > 0);
      for (int j = d; j < DIGITS; j++) begin
         if (nib(m_word, j) != 0) blanked = 1'b0;
      end
`endif
      if (blanked) return 10'b0;
      return 10'(1 << code);
   endfunction

   task automatic model_update();
      m_xfer = 1'b0;
      if (rst) begin
         m_active = 1'b0;
         m_pos    = 0;
         m_word   = '0;
         m_err    = 1'b0;
      end else if (in_valid && m_ready()) begin
         m_xfer   = 1'b1;
         m_active = 1'b1;
         m_pos    = 0;
         m_word   = in_bcd;
         for (int d = 0; d < DIGITS; d++) begin
            if (nib(in_bcd, d) > 9) m_err = 1'b1;
         end
      end else if (m_active) begin
         m_pos = (m_pos + 1) % FRAME;
      end
   endtask

   // One clock: model advances on the edge, outputs are sampled at the falling edge.
   task automatic clk_step();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_bcd = 16'h0000;
      for (int c = 0; c < 6; c++) begin
         if (c == 3) rst = 1'b0;
         clk_step();
         checks++;
         if (digit_sel !== 4'b0000) begin errors++; $display("FAIL reset digit_sel got %b want 0000", digit_sel); end
         checks++;
         if (out !== 10'b0) begin errors++; $display("FAIL reset out got %b want 0", out); end
         checks++;
         if (err !== 1'b0) begin errors++; $display("FAIL reset err got %b want 0", err); end
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
      end
   endtask

   task automatic test_scan();
      in_bcd = 16'h1905;
      in_valid = 1'b1;
      clk_step();
      in_valid = 1'b0;
      checks++;
      if (out !== 10'b00_0010_0000) begin errors++; $display("FAIL scan_first out got %b want 0000100000", out); end
      for (int c = 0; c < 2 * FRAME; c++) begin
         checks++;
         if (digit_sel !== exp_sel()) begin errors++; $display("FAIL scan digit_sel got %b want %b pos %0d", digit_sel, exp_sel(), m_pos); end
         checks++;
         if (out !== exp_out()) begin errors++; $display("FAIL scan out got %b want %b pos %0d", out, exp_out(), m_pos); end
         checks++;
         if (in_ready !== m_ready()) begin errors++; $display("FAIL scan in_ready got %b want %b pos %0d", in_ready, m_ready(), m_pos); end
         checks++;
         if (err !== m_err) begin errors++; $display("FAIL scan err got %b want %b", err, m_err); end
         clk_step();
      end
   endtask

   task automatic test_hold_ready();
      int guard = 0;
      while (m_pos != 4 && guard < 40) begin clk_step(); guard++; end
      checks++;
      if (m_pos != 4) begin errors++; $display("FAIL hold_sync pos got %0d want 4", m_pos); end
      in_bcd = 16'h0042;
      in_valid = 1'b1;
      guard = 0;
      m_xfer = 1'b0;
      while (!m_xfer && guard < 2 * FRAME) begin
         checks++;
         if (in_ready !== m_ready()) begin errors++; $display("FAIL hold in_ready got %b want %b", in_ready, m_ready()); end
         checks++;
         if (out !== exp_out()) begin errors++; $display("FAIL hold out got %b want %b", out, exp_out()); end
         clk_step();
         guard++;
      end
      in_valid = 1'b0;
      checks++;
      if (!m_xfer) begin errors++; $display("FAIL hold_xfer got 0 want 1"); end
      checks++;
      if (out !== 10'b00_0000_0100) begin errors++; $display("FAIL hold_new out got %b want 0000000100", out); end
      for (int c = 0; c < FRAME; c++) begin
         checks++;
         if (digit_sel !== exp_sel()) begin errors++; $display("FAIL hold_frame digit_sel got %b want %b", digit_sel, exp_sel()); end
         checks++;
         if (out !== exp_out()) begin errors++; $display("FAIL hold_frame out got %b want %b", out, exp_out()); end
         clk_step();
      end
   endtask

   // Waits for the frame boundary, transfers w, then follows one full frame.
   task automatic test_words(input logic [15:0] w, input string tag);
      int guard = 0;
      while (!m_ready() && guard < 2 * FRAME) begin clk_step(); guard++; end
      checks++;
      if (!m_ready()) begin errors++; $display("FAIL %s wait_ready got 0 want 1", tag); end
      in_bcd = w;
      in_valid = 1'b1;
      clk_step();
      in_valid = 1'b0;
      for (int c = 0; c < FRAME; c++) begin
         checks++;
         if (digit_sel !== exp_sel()) begin errors++; $display("FAIL %s digit_sel got %b want %b", tag, digit_sel, exp_sel()); end
         checks++;
         if (out !== exp_out()) begin errors++; $display("FAIL %s out got %b want %b pos %0d", tag, out, exp_out(), m_pos); end
         checks++;
         if (err !== m_err) begin errors++; $display("FAIL %s err got %b want %b", tag, err, m_err); end
         checks++;
         if (in_ready !== m_ready()) begin errors++; $display("FAIL %s in_ready got %b want %b", tag, in_ready, m_ready()); end
         clk_step();
      end
   endtask

   task automatic test_invalid();
      test_words(16'h00A3, "invalid");
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL invalid_err got %b want 1", err); end
      test_words(16'h0001, "sticky");
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL sticky_err got %b want 1", err); end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      while (!(m_active && (m_pos / SCAN_DIV) == 2) && guard < 2 * FRAME) begin clk_step(); guard++; end
      checks++;
      if (digit_sel !== 4'b0100) begin errors++; $display("FAIL rstmid_sync digit_sel got %b want 0100", digit_sel); end
      rst = 1'b1;
      in_valid = 1'b1;
      in_bcd = 16'h9999;
      clk_step();
      rst = 1'b0;
      in_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (digit_sel !== 4'b0000) begin errors++; $display("FAIL rstmid digit_sel got %b want 0000", digit_sel); end
         checks++;
         if (out !== 10'b0) begin errors++; $display("FAIL rstmid out got %b want 0", out); end
         checks++;
         if (err !== 1'b0) begin errors++; $display("FAIL rstmid err got %b want 0", err); end
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid in_ready got %b want 1", in_ready); end
         clk_step();
      end
      in_bcd = 16'h3217;
      in_valid = 1'b1;
      clk_step();
      in_valid = 1'b0;
      checks++;
      if (digit_sel !== 4'b0001) begin errors++; $display("FAIL restart digit_sel got %b want 0001", digit_sel); end
      checks++;
      if (out !== 10'b00_1000_0000) begin errors++; $display("FAIL restart out got %b want 0010000000", out); end
   endtask

   task automatic test_random();
      logic [15:0] w;
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 79) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         for (int d = 0; d < DIGITS; d++) begin
            case ($urandom_range(0, 7))
               0:       w[d*4 +: 4] = 4'($urandom_range(10, 15));
               1, 2:    w[d*4 +: 4] = 4'd0;
               default: w[d*4 +: 4] = 4'($urandom_range(0, 9));
            endcase
         end
         in_bcd = w;
         clk_step();
         checks++;
         if (digit_sel !== exp_sel()) begin errors++; $display("FAIL random digit_sel got %b want %b", digit_sel, exp_sel()); end
         checks++;
         if (out !== exp_out()) begin errors++; $display("FAIL random out got %b want %b word %h pos %0d", out, exp_out(), m_word, m_pos); end
         checks++;
         if (err !== m_err) begin errors++; $display("FAIL random err got %b want %b", err, m_err); end
         checks++;
         if (in_ready !== m_ready()) begin errors++; $display("FAIL random in_ready got %b want %b", in_ready, m_ready()); end
      end
      rst = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_bcd = 16'h0000;
      test_reset();
      test_scan();
      test_hold_ready();
      test_invalid();
      test_reset_mid();
      test_words(16'h0042, "words_0042");
      test_words(16'h0000, "words_0000");
      test_words(16'h0A00, "words_0A00");
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
